comparator_seq_multimode: RTL
=============================

// Module: comparator_seq_multimode
// PURPOSE
//  Multi-cycle magnitude comparator for wide operands. Compares A and B one chunk per cycle,
//  starting at the MSB chunk, and stops at the first chunk that differs.
//  Supports signed/unsigned operands and six relational modes behind a start/done handshake.
//  Used where a single-cycle DATA_WIDTH compare does not meet timing, e.g. threshold checks in the datapath.
// PARAMETERS
//  DATA_WIDTH   13  operand width, bits (>=2)
//  CHUNK_WIDTH  4   bits compared per cycle (1..DATA_WIDTH)
//  NUM_CHUNKS   (localparam) ceil(DATA_WIDTH/CHUNK_WIDTH); operands zero-extended at MSB to NUM_CHUNKS*CHUNK_WIDTH
// PORTS
//  clk_i       in   1           clock, rising edge
//  rst_n_i     in   1           synchronous reset, active-low
//  start_i     in   1           request; sampled only in IDLE
//  A_i         in   DATA_WIDTH  operand A, captured when start accepted
//  B_i         in   DATA_WIDTH  operand B, captured when start accepted
//  mode_i      in   3           0 LT, 1 LE, 2 GT, 3 GE, 4 EQ, 5 NE, 6/7 reserved; captured with operands
//  signed_i    in   1           1 = two's-complement operands; captured with operands
//  busy_o      out  1           comparison in progress
//  done_o      out  1           one-cycle pulse, results valid
//  result_o    out  1           relation selected by mode holds
//  a_lt_b_o    out  1           A < B (per captured signedness)
//  a_eq_b_o    out  1           A == B
//  a_gt_b_o    out  1           A > B
// BEHAVIOUR
//  - Reset (rst_n_i=0 at a rising edge): state IDLE; all outputs 0; capture registers cleared.
//  - FSM: IDLE -> COMPARE on start_i=1; COMPARE -> IDLE on deciding edge. No other states.
//  - Capture: at the accepting edge, register A, B, mode and signedness. If signed_i=1, invert bit DATA_WIDTH-1
//    of both A and B before zero-extension. The rest of the compare is then unsigned.
//  - COMPARE: a chunk index starts at NUM_CHUNKS-1. Each cycle, compare chunk[idx] of A and B.
//    * chunks differ: latch lt/gt from that chunk; this is the deciding edge.
//    * chunks equal, idx==0: latch eq; this is the deciding edge.
//    * otherwise: decrement idx and stay in COMPARE.
//  - Latency: start accepted at edge E0. Chunks examined k = NUM_CHUNKS - (index of first differing chunk),
//    or NUM_CHUNKS if A==B. Deciding edge is E0+k.
//    done_o=1 for exactly the cycle after E0+k. busy_o=1 from after E0 until E0+k.
//  - Results: exactly one of lt/eq/gt is 1 after done. result_o is derived from mode:
//    LT lt, LE lt|eq, GT gt, GE gt|eq, EQ eq, NE !eq; mode 6/7 gives 0.
//    Result outputs hold until the next accepted start, then clear to 0 at that edge.
//  - start_i while busy_o=1: ignored; the captured operands and the in-flight result are not disturbed.
//  - start_i=1 in the done_o cycle: accepted (FSM is IDLE). Back-to-back throughput is one op per k+1 cycles.
//  - Input changes on A_i/B_i/mode_i/signed_i after capture: no effect.
//  - Reset mid-COMPARE: aborts the compare; no done_o pulse; all outputs 0 on the next cycle.
//  - CHUNK_WIDTH >= DATA_WIDTH: NUM_CHUNKS=1; every op takes k=1.
// TESTING (DATA_WIDTH=13, CHUNK_WIDTH=4, NUM_CHUNKS=4 unless noted)
//  1. Unsigned, A=5, B=9, mode LT: chunks differ only at idx0 -> done_o 4 cycles after start; lt=1, result_o=1.
//  2. Unsigned, A=0x1000, B=0x0FFF, mode GE: differ at idx3 -> done_o 1 cycle after start; gt=1, result_o=1.
//  3. A=0x1FFF, B=1, mode LT: signed_i=1 -> lt=1, result_o=1; repeat with signed_i=0 -> gt=1, result_o=0.
//  4. A=B=0x0ABC: mode EQ -> eq=1, result_o=1, done_o after 4 cycles; mode NE -> result_o=0; mode 7 -> result_o=0.
//  5. Pulse start_i with new operands in cycles 1-2 of a busy op: first op's result is unchanged and done_o fires once.
//     Then a new start in the done_o cycle is accepted and results clear.
//  6. Assert rst_n_i=0 in the 2nd COMPARE cycle: no done_o; busy_o and all result outputs read 0 after that edge;
//     a new op then completes normally.

Source files
------------

// File: rtl/comparator_seq_multimode_if.sv
// Request/response bundle for the sequential multi-mode comparator.
// The master drives operands and start; the slave (comparator) returns status and relations.
interface comparator_seq_multimode_if #(
    parameter int DATA_WIDTH = 13
);
    logic                  start_i;
    logic [DATA_WIDTH-1:0] A_i;
    logic [DATA_WIDTH-1:0] B_i;
    logic [2:0]            mode_i;
    logic                  signed_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  result_o;
    logic                  a_lt_b_o;
    logic                  a_eq_b_o;
    logic                  a_gt_b_o;

    modport master (
        output start_i, A_i, B_i, mode_i, signed_i,
        input  busy_o, done_o, result_o, a_lt_b_o, a_eq_b_o, a_gt_b_o
    );

    modport slave (
        input  start_i, A_i, B_i, mode_i, signed_i,
        output busy_o, done_o, result_o, a_lt_b_o, a_eq_b_o, a_gt_b_o
    );
endinterface

// File: rtl/comparator_seq_multimode.sv
// Multi-cycle magnitude comparator: walks operand chunks MSB-first, stops at the
// first differing chunk, and reports lt/eq/gt plus a mode-selected relation.
module comparator_seq_multimode #(
    parameter int DATA_WIDTH  = 13,
    parameter int CHUNK_WIDTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    comparator_seq_multimode_if.slave  bus
);
    localparam int NUM_CHUNKS = (DATA_WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
    localparam int EXT_W      = NUM_CHUNKS * CHUNK_WIDTH;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    localparam logic [2:0] M_LT = 3'd0;
    localparam logic [2:0] M_LE = 3'd1;
    localparam logic [2:0] M_GT = 3'd2;
    localparam logic [2:0] M_GE = 3'd3;
    localparam logic [2:0] M_EQ = 3'd4;
    localparam logic [2:0] M_NE = 3'd5;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_COMPARE = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [NUM_CHUNKS-1:0][CHUNK_WIDTH-1:0] r_a;
    logic [NUM_CHUNKS-1:0][CHUNK_WIDTH-1:0] r_b;
    logic [IDX_W-1:0]                       r_idx;
    logic [2:0]                             r_mode;
    logic                                   r_done;
    logic                                   r_lt;
    logic                                   r_eq;
    logic                                   r_gt;
    logic                                   r_result;

    logic [EXT_W-1:0]       w_a_ext;
    logic [EXT_W-1:0]       w_b_ext;
    logic [CHUNK_WIDTH-1:0] w_a_chunk;
    logic [CHUNK_WIDTH-1:0] w_b_chunk;
    logic                   w_chunk_lt;
    logic                   w_chunk_gt;
    logic                   w_chunk_eq;
    logic                   w_decide;
    logic                   w_accept;
    logic                   w_result;

    // Flipping the sign bit maps two's-complement order onto unsigned order,
    // so the chunk walk below never needs to know about signedness.
    always_comb begin
        w_a_ext                   = '0;
        w_b_ext                   = '0;
        w_a_ext[DATA_WIDTH-1:0]   = bus.A_i;
        w_b_ext[DATA_WIDTH-1:0]   = bus.B_i;
        if (bus.signed_i) begin
            w_a_ext[DATA_WIDTH-1] = ~bus.A_i[DATA_WIDTH-1];
            w_b_ext[DATA_WIDTH-1] = ~bus.B_i[DATA_WIDTH-1];
        end
    end

    assign w_a_chunk  = r_a[r_idx];
    assign w_b_chunk  = r_b[r_idx];
    assign w_chunk_lt = (w_a_chunk < w_b_chunk);
    assign w_chunk_gt = (w_a_chunk > w_b_chunk);
    assign w_chunk_eq = (w_a_chunk == w_b_chunk);
    assign w_decide   = (r_state == S_COMPARE) && (!w_chunk_eq || (r_idx == '0));

    // Relation for the deciding edge, evaluated from the chunk verdict directly.
    always_comb begin
        w_result = 1'b0;
        case (r_mode)
            M_LT:    w_result = w_chunk_lt;
            M_LE:    w_result = w_chunk_lt | w_chunk_eq;
            M_GT:    w_result = w_chunk_gt;
            M_GE:    w_result = w_chunk_gt | w_chunk_eq;
            M_EQ:    w_result = w_chunk_eq;
            M_NE:    w_result = !w_chunk_eq;
            default: w_result = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start_i) begin
                    w_accept     = 1'b1;
                    w_state_next = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (w_decide) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_a      <= '0;
            r_b      <= '0;
            r_idx    <= '0;
            r_mode   <= '0;
            r_done   <= 1'b0;
            r_lt     <= 1'b0;
            r_eq     <= 1'b0;
            r_gt     <= 1'b0;
            r_result <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_a      <= w_a_ext;
                r_b      <= w_b_ext;
                r_mode   <= bus.mode_i;
                r_idx    <= IDX_W'(NUM_CHUNKS - 1);
                r_lt     <= 1'b0;
                r_eq     <= 1'b0;
                r_gt     <= 1'b0;
                r_result <= 1'b0;
            end else if (r_state == S_COMPARE) begin
                if (w_decide) begin
                    r_lt     <= w_chunk_lt;
                    r_eq     <= w_chunk_eq;
                    r_gt     <= w_chunk_gt;
                    r_result <= w_result;
                    r_done   <= 1'b1;
                end else begin
                    r_idx <= r_idx - 1'b1;
                end
            end
        end
    end

    assign bus.busy_o   = (r_state == S_COMPARE);
    assign bus.done_o   = r_done;
    assign bus.result_o = r_result;
    assign bus.a_lt_b_o = r_lt;
    assign bus.a_eq_b_o = r_eq;
    assign bus.a_gt_b_o = r_gt;
endmodule
